// File: rtl/crypto_job_sched.sv
// crypto_job_sched: two-requester round-robin front end for a fixed-latency
// crypto pipeline. One job in flight; the result is held until the consumer
// takes it.
// Optional feature macro: CRYPTO_SCHED_KEYCHK_EN. When it is defined, jobs
// with key[0]=1 are rejected without being issued and return rsp_err=1.
//
// state | meaning
// IDLE  | waiting for a request, grants one per visit
// ISSUE | pipe_issue strobe high, pipe_data/pipe_key presented
// WAIT  | counting down the pipeline latency
// RESP  | result held until rsp_valid && rsp_ready
module crypto_job_sched #(
    parameter int LATENCY = 12
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [15:0] req0_data,
    input  logic [5:0]  req0_key,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [15:0] req1_data,
    input  logic [5:0]  req1_key,
    output logic [15:0] pipe_data,
    output logic [5:0]  pipe_key,
    output logic        pipe_issue,
    input  logic [15:0] pipe_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_data,
    output logic        rsp_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        ptr_q;
    logic [15:0] pipe_data_q;
    logic [5:0]  pipe_key_q;
    logic        pipe_issue_q;
    logic        rsp_valid_q;
    logic        rsp_id_q;
    logic [15:0] rsp_data_q;

    logic        gnt_valid;
    logic        gnt_id;
    logic [15:0] gnt_data;
    logic [5:0]  gnt_key;
    logic        key_reject;

    // Round-robin grant, only offered while idle; both valid -> pointer wins.
    always_comb begin
        gnt_valid = (state_q == S_IDLE) && (req0_valid || req1_valid);
        gnt_id    = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        gnt_data  = gnt_id ? req1_data : req0_data;
        gnt_key   = gnt_id ? req1_key  : req0_key;
    end

`ifdef CRYPTO_SCHED_KEYCHK_EN
    logic rsp_err_q;
    assign key_reject = gnt_key[0];
    assign rsp_err    = rsp_err_q;
`else
    assign key_reject = 1'b0;
    assign rsp_err    = 1'b0;
`endif

    assign req0_ready = gnt_valid && !gnt_id;
    assign req1_ready = gnt_valid &&  gnt_id;
    assign pipe_data  = pipe_data_q;
    assign pipe_key   = pipe_key_q;
    assign pipe_issue = pipe_issue_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_data   = rsp_data_q;

    // Sequencer: accept -> issue strobe -> latency countdown -> held response.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            ptr_q        <= 1'b0;
            pipe_data_q  <= '0;
            pipe_key_q   <= '0;
            pipe_issue_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_data_q   <= '0;
`ifdef CRYPTO_SCHED_KEYCHK_EN
            rsp_err_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_valid) begin
                        ptr_q    <= ~gnt_id;
                        rsp_id_q <= gnt_id;
                        if (key_reject) begin
                            // Rejected job: straight to response, pipeline untouched.
                            state_q     <= S_RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= '0;
`ifdef CRYPTO_SCHED_KEYCHK_EN
                            rsp_err_q   <= 1'b1;
`endif
                        end else begin
                            state_q      <= S_ISSUE;
                            pipe_issue_q <= 1'b1;
                            pipe_data_q  <= gnt_data;
                            pipe_key_q   <= gnt_key;
`ifdef CRYPTO_SCHED_KEYCHK_EN
                            rsp_err_q    <= 1'b0;
`endif
                        end
                    end
                end
                S_ISSUE: begin
                    pipe_issue_q <= 1'b0;
                    cnt_q        <= CNT_LOAD;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 8'd0) begin
                        rsp_data_q  <= pipe_result;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_job_sched.sv
// Directed bench for crypto_job_sched. The pipeline model returns
// pipe_data << 1 only in the cycle exactly LATENCY cycles after pipe_issue,
// and 16'hDEAD at any other time.
module tb_crypto_job_sched;

    localparam int LAT = 12;

    logic        clk1;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [15:0] req0_data, req1_data;
    logic [5:0]  req0_key, req1_key;
    logic [15:0] pipe_data;
    logic [5:0]  pipe_key;
    logic        pipe_issue;
    logic [15:0] pipe_result;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_data;

    int checks   = 0;
    int failures = 0;
    int lat_cnt;

    crypto_job_sched #(.LATENCY(LAT)) dut (
        .clk1(clk1), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data(req0_data), .req0_key(req0_key),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data(req1_data), .req1_key(req1_key),
        .pipe_data(pipe_data), .pipe_key(pipe_key), .pipe_issue(pipe_issue),
        .pipe_result(pipe_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Pipeline model: counts cycles since the last issue strobe.
    always @(posedge clk1 or posedge rst) begin
        if (rst)             lat_cnt <= 0;
        else if (pipe_issue) lat_cnt <= 1;
        else if (lat_cnt != 0 && lat_cnt < 1000) lat_cnt <= lat_cnt + 1;
    end
    assign pipe_result = (lat_cnt == LAT) ? {pipe_data[14:0], 1'b0} : 16'hDEAD;

    // Both readies in one cycle is never allowed.
    always @(negedge clk1) begin
        if (!rst) begin
            checks++;
            assert (!(req0_ready === 1'b1 && req1_ready === 1'b1)) else begin
                failures++;
                $error("FAIL both_ready observed=11 expected=not both");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req0_ready"}, req0_ready, 0);
        chk({pfx, "_req1_ready"}, req1_ready, 0);
        chk({pfx, "_pipe_issue"}, pipe_issue, 0);
        chk({pfx, "_pipe_data"},  pipe_data,  0);
        chk({pfx, "_pipe_key"},   pipe_key,   0);
        chk({pfx, "_rsp_valid"},  rsp_valid,  0);
        chk({pfx, "_rsp_id"},     rsp_id,     0);
        chk({pfx, "_rsp_data"},   rsp_data,   0);
        chk({pfx, "_rsp_err"},    rsp_err,    0);
    endtask

    // k = cycles after the accepting edge until rsp_valid is seen (ISSUE cycle is 1).
    task automatic wait_rsp(output int k, output int issues);
        k = 1;
        issues = 0;
        while (rsp_valid !== 1'b1 && k < 200) begin
            if (pipe_issue === 1'b1) issues++;
            step();
            k++;
        end
    endtask

    initial begin
        int k, iss, n, exp_id, seen;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_data = 0; req1_data = 0; req0_key = 0; req1_key = 0;
        rsp_ready = 0;
        #2;
        chk_reset_vals("por");
        step(); step();
        rst = 1'b0;
        step();

        // Single job from requester 0.
        req0_valid = 1; req0_data = 16'h1234; req0_key = 6'b001010;
        #1;
        chk("t1_req0_ready", req0_ready, 1);
        chk("t1_req1_ready", req1_ready, 0);
        step();
        req0_valid = 0; req0_data = 0;
        chk("t1_pipe_issue", pipe_issue, 1);
        chk("t1_pipe_data", pipe_data, 16'h1234);
        chk("t1_pipe_key", pipe_key, 6'b001010);
        wait_rsp(k, iss);
        chk("t1_latency", k, LAT + 2);
        chk("t1_issue_count", iss, 1);
        chk("t1_rsp_id", rsp_id, 0);
        chk("t1_rsp_data", rsp_data, 16'h2468);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_pipe_data_hold", pipe_data, 16'h1234);
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("t1_rsp_done", rsp_valid, 0);

        // Reset during WAIT drops the job and clears the pointer.
        req0_valid = 1; req0_data = 16'h0F0F; req0_key = 6'b000010;
        #1;
        chk("t2_req0_ready", req0_ready, 1);
        step();
        req0_valid = 0;
        repeat (5) step();
        chk("t2_still_waiting", rsp_valid, 0);
        rst = 1'b1;
        #1;
        chk_reset_vals("t2_async");
        step(); step();
        rst = 1'b0;
        #1;
        chk_reset_vals("t2_after");
        rsp_ready = 1;
        seen = 0;
        repeat (LAT + 8) begin
            step();
            if (rsp_valid === 1'b1) seen = 1;
        end
        chk("t2_no_dropped_rsp", seen, 0);

        // Contention: both requesters valid, grants alternate from 0.
        req0_valid = 1; req0_data = 16'hABCD; req0_key = 6'b000000;
        req1_valid = 1; req1_data = 16'hFFFF; req1_key = 6'b000110;
        for (int j = 0; j < 4; j++) begin
            exp_id = j % 2;
            n = 0;
            #1;
            while (!(req0_ready === 1'b1 || req1_ready === 1'b1) && n < 50) begin
                step();
                #1;
                n++;
            end
            chk("t3_grant_seen", n < 50, 1);
            chk("t3_grant_idx", req1_ready, exp_id);
            chk("t3_grant_other", req0_ready, exp_id == 0);
            step();
            wait_rsp(k, iss);
            chk("t3_latency", k, LAT + 2);
            chk("t3_rsp_id", rsp_id, exp_id);
            chk("t3_rsp_data", rsp_data, (exp_id == 1) ? 16'hFFFE : 16'h579A);
            step();
        end
        req0_valid = 0; req1_valid = 0; rsp_ready = 0;
        step();

        // Backpressure: response held 20 cycles, no new grants or issues.
        req1_valid = 1; req1_data = 16'h5555; req1_key = 6'b000100;
        #1;
        chk("t4_req1_ready", req1_ready, 1);
        step();
        req1_valid = 0;
        wait_rsp(k, iss);
        chk("t4_latency", k, LAT + 2);
        req0_valid = 1; req1_valid = 1;
        repeat (20) begin
            #1;
            chk("t4_hold_valid", rsp_valid, 1);
            chk("t4_hold_data", rsp_data, 16'hAAAA);
            chk("t4_hold_id", rsp_id, 1);
            chk("t4_no_ready", {req0_ready, req1_ready}, 0);
            chk("t4_no_issue", pipe_issue, 0);
            step();
        end
        req0_valid = 0; req1_valid = 0;
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("t4_released", rsp_valid, 0);

        // Reserved key bit set on requester 1.
        req1_valid = 1; req1_data = 16'h1357; req1_key = 6'b100111;
        #1;
        chk("t5_req1_ready", req1_ready, 1);
        step();
        req1_valid = 0;
        wait_rsp(k, iss);
        chk("t5_rsp_id", rsp_id, 1);
`ifdef CRYPTO_SCHED_KEYCHK_EN
        chk("t5_latency", k, 1);
        chk("t5_issue_count", iss, 0);
        chk("t5_rsp_err", rsp_err, 1);
        chk("t5_rsp_data", rsp_data, 16'h0000);
        chk("t5_pipe_data", pipe_data, 16'h5555);
        chk("t5_pipe_key", pipe_key, 6'b000100);
`else
        chk("t5_latency", k, LAT + 2);
        chk("t5_issue_count", iss, 1);
        chk("t5_rsp_err", rsp_err, 0);
        chk("t5_rsp_data", rsp_data, 16'h26AE);
        chk("t5_pipe_key", pipe_key, 6'b100111);
`endif
        rsp_ready = 1;
        step();
        rsp_ready = 0;
        chk("t5_released", rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crypto_job_sched.md
CRYPTO_JOB_SCHED -- requirements
Module: crypto_job_sched

Interface
REQ-001 Parameter LATENCY, default 12, clk1 cycles from pipe_issue to valid pipe_result; legal range 1..255.
REQ-002 clk1  input  1  sole clock, rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has a job pending.
REQ-005 req0_ready / req1_ready  output  1  job from requester N accepted this cycle.
REQ-006 req0_data / req1_data  input  16  plaintext word from requester N.
REQ-007 req0_key / req1_key  input  6  key_bits: [5:3] shift, [2:1] FSM mode, [0] reserved.
REQ-008 pipe_data  output  16  input_data driven to the crypto pipeline.
REQ-009 pipe_key  output  6  key_bits driven to the crypto pipeline.
REQ-010 pipe_issue  output  1  one-cycle strobe marking a new job on pipe_data/pipe_key.
REQ-011 pipe_result  input  16  output_data from the crypto pipeline.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  consumer accepts result.
REQ-014 rsp_id  output  1  requester index owning rsp_data.
REQ-015 rsp_data  output  16  captured pipeline result.
REQ-016 rsp_err  output  1  job rejected, not issued.

Function
REQ-017 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one job in flight at any time.
REQ-018 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally for that cycle only, latch data/key/id at the clock edge, go to ISSUE.
REQ-019 Arbitration round-robin: both valid -> grant requester equal to priority pointer; one valid -> grant it regardless of pointer.
REQ-020 Priority pointer set to the non-granted index after each grant; reset value 0.
REQ-021 reqN_ready is never asserted outside IDLE, and never for both requesters in the same cycle.
REQ-022 ISSUE: pipe_issue=1 for exactly one cycle; pipe_data/pipe_key take latched values that cycle; load counter with LATENCY-1; go to WAIT.
REQ-023 pipe_data/pipe_key hold their value until the next ISSUE (slower pipeline clock domains sample them).
REQ-024 WAIT: decrement counter each cycle; at counter==0 capture pipe_result into rsp_data, go to RESP.
REQ-025 Issue-to-rsp_valid latency is LATENCY+1 cycles; accept-to-rsp_valid is LATENCY+2 cycles.
REQ-026 RESP: rsp_valid=1, rsp_id/rsp_data/rsp_err stable until rsp_valid && rsp_ready; on handshake go to IDLE.
REQ-027 rsp_ready asserted while rsp_valid is low has no effect; requester inputs are ignored outside IDLE.
REQ-028 Back-to-back: a new grant may occur in the cycle after the RESP handshake (IDLE lasts at least one cycle).

Reset
REQ-029 rst asserted, any state: FSM to IDLE, counter 0, pointer 0, in-flight job dropped with no response.
REQ-030 Reset values: reqN_ready 0, pipe_issue 0, pipe_data 0, pipe_key 0, rsp_valid 0, rsp_id 0, rsp_data 0, rsp_err 0.

Configuration
REQ-031 Macro CRYPTO_SCHED_KEYCHK_EN defined: a latched job with key[0]=1 skips ISSUE/WAIT, goes IDLE->RESP-path with rsp_err=1, rsp_data=16'h0000, no pipe_issue, pipe_data/pipe_key unchanged.
REQ-032 Macro undefined: key forwarded unchanged including key[0]; rsp_err tied to 0; all jobs issued.

Verification
REQ-033 Single job: req0 data 16'h1234 key 6'b001010, pipe_result modelled as 16'h2468 -> one pipe_issue, rsp_valid exactly LATENCY+2 cycles after accept, rsp_id 0, rsp_data 16'h2468.
REQ-034 Contention: req0 and req1 both valid continuously (16'hABCD, 16'hFFFF) -> grants alternate 0,1,0,1; never both ready in one cycle.
REQ-035 Backpressure: rsp_ready held low 20 cycles -> rsp_valid/rsp_data stable, no second reqN_ready, no pipe_issue until handshake.
REQ-036 Reset mid-WAIT: rst pulse 2 cycles during WAIT -> all outputs at REQ-030 values, no rsp_valid for dropped job, next job granted to requester 0.
REQ-037 With CRYPTO_SCHED_KEYCHK_EN: req1 key 6'b100111 -> no pipe_issue, rsp_err 1, rsp_id 1, rsp_data 16'h0000; without macro same stimulus issues normally, rsp_err 0.
